wb_stage: RTL and testbench

Writeback stage of the five-stage core. Latches one instruction per cycle from the memory stage, selects the result source (ALU, aligned load data, or PC+4), and drives the register file's single synchronous write port. It stalls the pipeline while a load awaits its data-memory response and counts retired instructions. The register file has no reset and no x0 protection of its own, so this block never writes x0.

---
 rtl/core_pkg.sv | 17 +
 rtl/load_align.sv | 41 ++++
 rtl/wb_stage.sv | 111 +++++++++++
 tb/tb_wb_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Core-wide shared definitions: datapath width, writeback source
// encodings and load funct3 codes used by memory, decode and writeback.
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Extracts and extends a byte/halfword/word from a raw data-memory word.
// Purely combinational; shared by writeback and the forwarding path.
module load_align
   import core_pkg::*;
(
   input  logic [31:0] data,
   input  logic [2:0]  funct3,
   input  logic [1:0]  lo,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // pick the addressed byte and halfword lanes (halfword ignores lo[0])
   always_comb begin
      byte_v = data[7:0];
      case (lo)
         2'd0: byte_v = data[7:0];
         2'd1: byte_v = data[15:8];
         2'd2: byte_v = data[23:16];
         2'd3: byte_v = data[31:24];
         default: byte_v = data[7:0];
      endcase
      half_v = lo[1] ? data[31:16] : data[15:0];
   end

   // extend according to load type; unknown codes pass the full word
   always_comb begin
      result = data;
      case (funct3)
         F3_LB:   result = {{24{byte_v[7]}}, byte_v};
         F3_LBU:  result = {24'd0, byte_v};
         F3_LH:   result = {{16{half_v[15]}}, half_v};
         F3_LHU:  result = {16'd0, half_v};
         F3_LW:   result = data;
         default: result = data;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: latches one instruction from the memory stage, selects
// the result source and drives the register-file write port. Stalls the
// pipeline while a load waits for its data response; never writes x0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// EMPTY    | no instruction held in the writeback register
// READY    | instruction held and its result is available this cycle
// WAIT_LD  | load held, data response not yet arrived; upstream stalls
module wb_stage
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        m_valid,
   input  logic        m_reg_we,
   input  logic [4:0]  m_rd_addr,
   input  logic [1:0]  m_wb_sel,
   input  logic [31:0] m_alu_result,
   input  logic [31:0] m_pc,
   input  logic [2:0]  m_funct3,
   input  logic        dmem_resp_valid,
   input  logic [31:0] dmem_resp_data,
   output logic        wb_stall,
   output logic        we,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic [31:0] instret
);

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_READY   = 2'd1;
   localparam logic [1:0] ST_WAIT_LD = 2'd2;

   logic        p_valid;
   logic        p_we;
   logic [4:0]  p_rd;
   logic [1:0]  p_sel;
   logic [31:0] p_alu;
   logic [31:0] p_pc4;
   logic [2:0]  p_funct3;
   logic [1:0]  p_lo;
   logic [31:0] instret_q;

   logic [1:0]  state;
   logic        retire;
   logic [31:0] ld_data;
   logic [31:0] result;

   load_align u_load_align (
      .data   (dmem_resp_data),
      .funct3 (p_funct3),
      .lo     (p_lo),
      .result (ld_data)
   );

   // state is derived from the held instruction and the response strobe
   always_comb begin
      state = ST_READY;
      if (!p_valid)
         state = ST_EMPTY;
      else if ((p_sel == WB_SEL_MEM) && !dmem_resp_valid)
         state = ST_WAIT_LD;
   end

   assign wb_stall = (state == ST_WAIT_LD);
   assign retire   = (state == ST_READY);

   // pipeline register; payload only loads on a valid instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         p_valid <= 1'b0;
      end else if (!wb_stall) begin
         p_valid <= m_valid;
         if (m_valid) begin
            p_we     <= m_reg_we;
            p_rd     <= m_rd_addr;
            p_sel    <= m_wb_sel;
            p_alu    <= m_alu_result;
            p_pc4    <= m_pc + 32'd4;
            p_funct3 <= m_funct3;
            p_lo     <= m_alu_result[1:0];
         end
      end
   end

   // result source; the reserved encoding falls back to the ALU value
   always_comb begin
      result = p_alu;
      case (p_sel)
         WB_SEL_MEM: result = ld_data;
         WB_SEL_PC4: result = p_pc4;
         default:    result = p_alu;
      endcase
   end

   assign we      = retire & p_we & (p_rd != 5'd0);
   assign wb_addr = we ? p_rd : 5'd0;
   assign wb_data = we ? result : 32'd0;

   // retired-instruction counter, wraps naturally at 2^32
   always_ff @(posedge clk) begin
      if (reset)
         instret_q <= 32'd0;
      else if (retire)
         instret_q <= instret_q + 32'd1;
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage. Expected register-file writes are queued
// by the stimulus; a negedge monitor pops and compares every write.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_valid;
   logic        m_reg_we;
   logic [4:0]  m_rd_addr;
   logic [1:0]  m_wb_sel;
   logic [31:0] m_alu_result;
   logic [31:0] m_pc;
   logic [2:0]  m_funct3;
   logic        dmem_resp_valid;
   logic [31:0] dmem_resp_data;
   logic        wb_stall;
   logic        we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] instret;

   int checks   = 0;
   int failures = 0;
   logic [36:0] exp_q[$];

   wb_stage dut (
      .clk             (clk),
      .reset           (reset),
      .m_valid         (m_valid),
      .m_reg_we        (m_reg_we),
      .m_rd_addr       (m_rd_addr),
      .m_wb_sel        (m_wb_sel),
      .m_alu_result    (m_alu_result),
      .m_pc            (m_pc),
      .m_funct3        (m_funct3),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_resp_data  (dmem_resp_data),
      .wb_stall        (wb_stall),
      .we              (we),
      .wb_addr         (wb_addr),
      .wb_data         (wb_data),
      .instret         (instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we_i, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
      m_valid      = 1'b1;
      m_reg_we     = we_i;
      m_rd_addr    = rd;
      m_wb_sel     = sel;
      m_alu_result = alu;
      m_pc         = pc;
      m_funct3     = f3;
   endtask

   // monitor: every write must match the head of the expected queue
   always @(negedge clk) begin
      if (!reset) begin
         if (we) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: addr=%0d data=0x%08h, none expected", wb_addr, wb_data);
            end else begin
               logic [36:0] e;
               e = exp_q.pop_front();
               chk("wb_addr", {27'd0, wb_addr}, {27'd0, e[36:32]});
               chk("wb_data", wb_data, e[31:0]);
            end
         end else begin
            chk("idle_port", {wb_data[31:5], wb_data[4:0] | wb_addr}, 32'd0);
         end
      end
   end

   initial begin
      reset = 1'b1;
      m_valid = 1'b0; m_reg_we = 1'b0; m_rd_addr = 5'd0; m_wb_sel = 2'd0;
      m_alu_result = 32'd0; m_pc = 32'd0; m_funct3 = 3'd0;
      dmem_resp_valid = 1'b0; dmem_resp_data = 32'd0;
      step(); step();
      chk("rst_stall", {31'd0, wb_stall}, 32'd0);
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_addr", {27'd0, wb_addr}, 32'd0);
      chk("rst_data", wb_data, 32'd0);
      chk("rst_instret", instret, 32'd0);
      reset = 1'b0;

      // ALU op rd=5
      drive(1'b1, 5'd5, 2'd0, 32'h1234_5678, 32'h0000_1000, 3'd0);
      exp_q.push_back({5'd5, 32'h1234_5678});
      step();
      m_valid = 1'b0;
      chk("alu_we", {31'd0, we}, 32'd1);
      step();
      chk("alu_instret", instret, 32'd1);

      // ALU op rd=0: retires but never writes
      drive(1'b1, 5'd0, 2'd0, 32'hFFFF_FFFF, 32'h0000_1004, 3'd0);
      step();
      m_valid = 1'b0;
      chk("x0_we", {31'd0, we}, 32'd0);
      step();
      chk("x0_instret", instret, 32'd2);

      // LB lo=3, response 3 cycles late
      drive(1'b1, 5'd7, 2'd1, 32'h0000_1003, 32'h0000_1008, 3'b000);
      step();
      m_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("lb_stall", {31'd0, wb_stall}, 32'd1);
         step();
      end
      exp_q.push_back({5'd7, 32'hFFFF_FF80});
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = 32'h80AA_BBCC;
      #1;
      chk("lb_stall_drop", {31'd0, wb_stall}, 32'd0);
      chk("lb_we", {31'd0, we}, 32'd1);
      chk("lb_instret_hold", instret, 32'd2);
      step();
      dmem_resp_valid = 1'b0;
      chk("lb_instret", instret, 32'd3);

      // LHU lo=2 with immediate response, then JAL at pc wrap
      drive(1'b1, 5'd9, 2'd1, 32'h0000_2002, 32'h0000_100C, 3'b101);
      step();
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = 32'hBEEF_0001;
      exp_q.push_back({5'd9, 32'h0000_BEEF});
      drive(1'b1, 5'd1, 2'd2, 32'h0000_0000, 32'hFFFF_FFFC, 3'd0);
      #1;
      chk("lhu_no_stall", {31'd0, wb_stall}, 32'd0);
      step();
      dmem_resp_valid = 1'b0;
      m_valid = 1'b0;
      exp_q.push_back({5'd1, 32'h0000_0000});
      chk("jal_we", {31'd0, we}, 32'd1);
      step();
      chk("b2b_instret", instret, 32'd5);

      // spurious response while empty
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = 32'hDEAD_BEEF;
      #1;
      chk("spur_we", {31'd0, we}, 32'd0);
      chk("spur_stall", {31'd0, wb_stall}, 32'd0);
      step();
      dmem_resp_valid = 1'b0;
      chk("spur_instret", instret, 32'd5);

      // reset during WAIT_LD drops the load; late response ignored
      drive(1'b1, 5'd3, 2'd1, 32'h0000_3000, 32'h0000_1010, 3'b010);
      step();
      m_valid = 1'b0;
      chk("rl_stall1", {31'd0, wb_stall}, 32'd1);
      step();
      chk("rl_stall2", {31'd0, wb_stall}, 32'd1);
      reset = 1'b1;
      step();
      chk("rl_stall_cleared", {31'd0, wb_stall}, 32'd0);
      chk("rl_instret", instret, 32'd0);
      reset = 1'b0;
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = 32'h5555_AAAA;
      #1;
      chk("rl_late_we", {31'd0, we}, 32'd0);
      step();
      dmem_resp_valid = 1'b0;
      chk("rl_late_instret", instret, 32'd0);

      // instret wrap from preloaded all-ones
      force dut.instret_q = 32'hFFFF_FFFF;
      step();
      release dut.instret_q;
      #1;
      chk("wrap_preload", instret, 32'hFFFF_FFFF);
      drive(1'b1, 5'd4, 2'd0, 32'h0000_00A5, 32'h0000_2000, 3'd0);
      exp_q.push_back({5'd4, 32'h0000_00A5});
      step();
      m_valid = 1'b0;
      step();
      chk("wrap_instret", instret, 32'd0);

      step();
      chk("sb_drain", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
